// File: rtl/adder_pkg.sv
// Shared constants for the registered carry-lookahead adder.
package adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 20;
  localparam int unsigned CLA_GROUP     = 4;

  function automatic int unsigned num_groups(input int unsigned width);
    return width / CLA_GROUP;
  endfunction

endpackage

// File: rtl/adder_cla4.sv
// 4-bit carry-lookahead slice: sum bits plus group generate/propagate.
module cla4
  import adder_pkg::*;
(
  input  logic [CLA_GROUP-1:0] a,
  input  logic [CLA_GROUP-1:0] b,
  input  logic                 cin,
  output logic [CLA_GROUP-1:0] sum,
  output logic                 grp_g,
  output logic                 grp_p
);

  logic [CLA_GROUP-1:0] g;
  logic [CLA_GROUP-1:0] p;
  logic [CLA_GROUP-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign sum   = p ^ c;
  assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign grp_p = &p;

endmodule

// File: rtl/adder.sv
// Single-stage registered adder: cla4 slices + group lookahead, 1-cycle latency.
module adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] res,
  output logic             c_out
);

  localparam int unsigned NG = num_groups(WIDTH);

  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [NG:0]      carry;
  logic [WIDTH-1:0] sum;

  for (genvar gi = 0; gi < NG; gi++) begin : g_slice
    cla4 u_cla4 (
      .a     (a[CLA_GROUP*gi +: CLA_GROUP]),
      .b     (b[CLA_GROUP*gi +: CLA_GROUP]),
      .cin   (carry[gi]),
      .sum   (sum[CLA_GROUP*gi +: CLA_GROUP]),
      .grp_g (grp_g[gi]),
      .grp_p (grp_p[gi])
    );
  end

  assign carry[0] = c_in;

  // Each group carry is a flat sum of products over group G/P and c_in,
  // so no carry ripples through a lower group's carry output.
  for (genvar k = 1; k <= NG; k++) begin : g_lookahead
    logic [k:0] terms;
    assign terms[k] = c_in & (&grp_p[k-1:0]);
    for (genvar j = 0; j < k; j++) begin : g_term
      if (j == k - 1) begin : g_top
        assign terms[j] = grp_g[j];
      end else begin : g_mid
        assign terms[j] = grp_g[j] & (&grp_p[k-1:j+1]);
      end
    end
    assign carry[k] = |terms;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res       <= '0;
      c_out     <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        res   <= sum;
        c_out <= carry[NG];
      end
    end
  end

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: scoreboard of expected sums, per-scenario tasks.
module tb_adder;

  localparam int unsigned W = 20;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c_out;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         out_valid;
  logic [W-1:0] res;
  logic         c_out;

  exp_t q[$];
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .res       (res),
    .c_out     (c_out)
  );

  task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    logic [W:0] s;
    a        = av;
    b        = bv;
    c_in     = cv;
    in_valid = 1'b1;
    s = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    q.push_back('{res: s[W-1:0], c_out: s[W]});
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 20'h12345;
    b        = 20'h00000;
    c_in     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if ({out_valid, c_out, res} !== {1'b0, 1'b0, {W{1'b0}}}) begin
        $display("FAIL reset_hold cycle %0d: got v=%b c=%b res=%h want 0/0/00000", i, out_valid, c_out, res);
      end else passed++;
    end
    idle();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset_discard: out_valid=%b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_basic();
    exp_t e;
    drive(20'h12345, 20'h0ABCD, 1'b1);
    idle_after_edge_check: begin
      @(posedge clk); #1;
      idle();
      total++;
      if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", out_valid);
      else passed++;
      e = q.pop_front();
      total++;
      if ({c_out, res} !== {e.c_out, e.res})
        $display("FAIL basic_sum: got c=%b res=%h want c=%b res=%h", c_out, res, e.c_out, e.res);
      else passed++;
      total++;
      if ({c_out, res} !== {1'b0, 20'h1CF13})
        $display("FAIL basic_const: got c=%b res=%h want c=0 res=1cf13", c_out, res);
      else passed++;
    end
    @(posedge clk); #1;
    total++;
    if ({out_valid, c_out, res} !== {1'b0, e.c_out, e.res})
      $display("FAIL basic_hold: got v=%b c=%b res=%h want v=0 c=%b res=%h", out_valid, c_out, res, e.c_out, e.res);
    else passed++;
  endtask

  task automatic test_boundaries();
    exp_t e;
    logic [W-1:0] av [4] = '{20'hFFFFF, 20'hFFFFF, 20'h0000F, 20'h0FFFF};
    logic [W-1:0] bv [4] = '{20'h00001, 20'hFFFFF, 20'h00001, 20'h00000};
    logic         cv [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [W:0]   kv [4] = '{{1'b1, 20'h00000}, {1'b1, 20'hFFFFF}, {1'b0, 20'h00010}, {1'b0, 20'h10000}};
    for (int i = 0; i < 4; i++) begin
      drive(av[i], bv[i], cv[i]);
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1) $display("FAIL boundary_valid %0d: got %b want 1", i, out_valid);
      else passed++;
      e = q.pop_front();
      total++;
      if ({c_out, res} !== {e.c_out, e.res} || {c_out, res} !== kv[i])
        $display("FAIL boundary_sum %0d: got c=%b res=%h want c=%b res=%h", i, c_out, res, kv[i][W], kv[i][W-1:0]);
      else passed++;
    end
    idle();
    @(posedge clk); #1;
  endtask

  task automatic test_x_idle();
    logic [W-1:0] held_res;
    logic         held_c;
    held_res = res;
    held_c   = c_out;
    in_valid = 1'b0;
    a        = 'x;
    b        = 'x;
    c_in     = 1'bx;
    @(posedge clk); #1;
    total++;
    if ({out_valid, c_out, res} !== {1'b0, held_c, held_res})
      $display("FAIL x_idle: got v=%b c=%b res=%h want v=0 c=%b res=%h", out_valid, c_out, res, held_c, held_res);
    else passed++;
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [31:0] r1, r2, r3;
    void'($urandom(10531));
    for (int i = 0; i < 10; i++) begin
      r1 = $urandom;
      r2 = $urandom;
      r3 = $urandom;
      drive(r1[W-1:0], r2[W-1:0], r3[0]);
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1) $display("FAIL stream_valid %0d: got %b want 1", i, out_valid);
      else passed++;
      if (q.size() == 0) begin
        total++;
        $display("FAIL stream_queue %0d: scoreboard empty got 0 want 1 entry", i);
      end else begin
        e = q.pop_front();
        total++;
        if ({c_out, res} !== {e.c_out, e.res})
          $display("FAIL stream_sum %0d: got c=%b res=%h want c=%b res=%h", i, c_out, res, e.c_out, e.res);
        else passed++;
      end
    end
    idle();
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) $display("FAIL stream_end: out_valid=%b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    drive(20'h00ABC, 20'h00123, 1'b0);
    @(posedge clk); #1;
    e = q.pop_front();
    total++;
    if ({out_valid, c_out, res} !== {1'b1, e.c_out, e.res})
      $display("FAIL mid_pre: got v=%b c=%b res=%h want v=1 c=%b res=%h", out_valid, c_out, res, e.c_out, e.res);
    else passed++;
    drive(20'hF0F0F, 20'h0F0F1, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, c_out, res} !== {1'b0, 1'b0, {W{1'b0}}})
      $display("FAIL mid_async: got v=%b c=%b res=%h want 0/0/00000", out_valid, c_out, res);
    else passed++;
    drive(20'h11111, 20'h22222, 1'b0);
    q.delete();
    @(posedge clk); #1;
    total++;
    if ({out_valid, c_out, res} !== {1'b0, 1'b0, {W{1'b0}}})
      $display("FAIL mid_in_reset: got v=%b c=%b res=%h want 0/0/00000", out_valid, c_out, res);
    else passed++;
    idle();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) $display("FAIL mid_discard: out_valid=%b want 0", out_valid);
    else passed++;
    drive(20'h7FFFF, 20'h80000, 1'b1);
    @(posedge clk); #1;
    idle();
    e = q.pop_front();
    total++;
    if ({out_valid, c_out, res} !== {1'b1, e.c_out, e.res})
      $display("FAIL mid_first: got v=%b c=%b res=%h want v=1 c=%b res=%h", out_valid, c_out, res, e.c_out, e.res);
    else passed++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_x_idle();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/adder.md
ADDER -- requirements
Module: adder

Interface
REQ-001 Parameter WIDTH, default 20, operand/result width in bits; legal values are multiples of 4, 4..64.
REQ-002 Port clk, input, 1, single rising-edge clock for all state.
REQ-003 Port rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-004 Port in_valid, input, 1, high when a/b/c_in carry a new operation this cycle.
REQ-005 Port a, input, WIDTH, unsigned addend A.
REQ-006 Port b, input, WIDTH, unsigned addend B.
REQ-007 Port c_in, input, 1, carry into bit 0.
REQ-008 Port out_valid, output, 1, high for exactly one cycle per accepted operation, when res/c_out are valid.
REQ-009 Port res, output, WIDTH, registered sum bits [WIDTH-1:0].
REQ-010 Port c_out, output, 1, registered carry out of bit WIDTH-1.

Function
REQ-011 The block SHALL compute {c_out,res} = a + b + c_in, modulo 2^(WIDTH+1), with no truncation of the carry.
REQ-012 An operation SHALL be accepted on every rising clk edge where in_valid=1; there is no backpressure and no stall.
REQ-013 Latency SHALL be exactly 1 cycle: results of an operation accepted at edge N SHALL appear on res/c_out with out_valid=1 after edge N.
REQ-014 Throughput SHALL be one operation per cycle; back-to-back in_valid=1 SHALL produce back-to-back out_valid=1 with results in acceptance order.
REQ-015 When in_valid=0 at an edge, out_valid SHALL drop to 0 and res/c_out SHALL hold their previous values.
REQ-016 Wrap-around: all-ones + all-ones + 1 SHALL give res=all-ones, c_out=1; all-ones + 0 + 1 SHALL give res=0, c_out=1.
REQ-017 X/Z on a, b, c_in while in_valid=0 SHALL NOT affect any output.
REQ-018 Addition SHALL be combinational carry-lookahead within the single stage; no multi-cycle paths.

Reset
REQ-019 While rst_n=0, out_valid, res and c_out SHALL be 0, asynchronously, independent of clk.
REQ-020 An operation accepted in the cycle rst_n asserts SHALL be discarded; no output is produced for it after release.
REQ-021 After rst_n deasserts, the first in_valid=1 edge SHALL be accepted normally, with the 1-cycle latency.

Structure
REQ-022 A shared package SHALL hold the default width constant (20) and the CLA group size constant (4).
REQ-023 One sub-module, cla4, SHALL implement a 4-bit carry-lookahead slice with inputs a[3:0], b[3:0], cin and outputs sum[3:0], group generate, group propagate.
REQ-024 The top SHALL instantiate WIDTH/4 cla4 slices with a lookahead carry unit across groups, followed by the output register stage.

Verification
REQ-025 Reset: rst_n=0 with in_valid=1, a=0x12345 -> out_valid=0, res=0x00000, c_out=0 throughout.
REQ-026 Basic: a=0x12345, b=0x0ABCD, c_in=1, one valid cycle -> next cycle res=0x1CF13, c_out=0, out_valid=1; following cycle out_valid=0, res held.
REQ-027 Wrap: a=0xFFFFF, b=0x00001, c_in=0 -> res=0x00000, c_out=1; then a=0xFFFFF, b=0xFFFFF, c_in=1 -> res=0xFFFFF, c_out=1.
REQ-028 Streaming: 10 consecutive random valid operations (fixed seed 10531) -> 10 consecutive out_valid cycles, each matching a reference model, in order.
REQ-029 Reset mid-stream: assert rst_n=0 asynchronously between edges during streaming -> outputs go to 0 immediately; first valid after release yields a correct result after 1 cycle.
REQ-030 Group-carry boundary: a=0x0000F, b=0x00001, c_in=0 -> res=0x00010; a=0x0FFFF, b=0x00000, c_in=1 -> res=0x10000, c_out=0.
